// File: rtl/mmu_tlb_walker_if.sv
// CPU load/store port and memory bus of the MMU, bundled as one interface.
// slave: the MMU's view. master: the environment (CPU and memory) driving it.
interface mmu_tlb_walker_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] cpu_address;
    logic              cpu_read;
    logic              cpu_write;
    logic [DATA_W-1:0] cpu_write_data;
    logic              cpu_ready;
    logic              cpu_read_valid;
    logic [DATA_W-1:0] cpu_read_data;
    logic              cpu_write_done;
    logic              cpu_fault;
    logic [ADDR_W-1:0] cpu_fault_addr;

    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_write_data;
    logic [DATA_W-1:0] mem_read_data;
    logic              mem_ready;

    modport slave (
        input  cpu_address, cpu_read, cpu_write, cpu_write_data,
        output cpu_ready, cpu_read_valid, cpu_read_data, cpu_write_done,
        output cpu_fault, cpu_fault_addr,
        output mem_read, mem_write, mem_address, mem_write_data,
        input  mem_read_data, mem_ready
    );

    modport master (
        output cpu_address, cpu_read, cpu_write, cpu_write_data,
        input  cpu_ready, cpu_read_valid, cpu_read_data, cpu_write_done,
        input  cpu_fault, cpu_fault_addr,
        input  mem_read, mem_write, mem_address, mem_write_data,
        output mem_read_data, mem_ready
    );
endinterface

// File: rtl/mmu_tlb_walker.sv
// Blocking MMU: fully associative round-robin TLB plus single-level page table walker.
// Optional feature macro MMU_WRITE_PROTECT_EN: writes to non-writable pages fault.
module mmu_tlb_walker #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int PAGE_BITS   = 12,
    parameter int TLB_ENTRIES = 8
) (
    input  logic              clk,
    input  logic              reset,
    mmu_tlb_walker_if.slave   io,
    input  logic              translate_en,
    input  logic [ADDR_W-1:0] pt_base,
    input  logic              tlb_flush
);
    localparam int VPN_W = ADDR_W - PAGE_BITS;
    localparam int IDX_W = $clog2(TLB_ENTRIES);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_XLATE  = 2'd1;
    localparam logic [1:0] S_WALK   = 2'd2;
    localparam logic [1:0] S_ACCESS = 2'd3;

    logic [1:0]        state;
    logic [IDX_W-1:0]  rr_ptr;
    logic [TLB_ENTRIES-1:0] tlb_vld;
    logic [VPN_W-1:0]  tlb_vpn [TLB_ENTRIES];
    logic [VPN_W-1:0]  tlb_ppn [TLB_ENTRIES];
`ifdef MMU_WRITE_PROTECT_EN
    logic              tlb_wr  [TLB_ENTRIES];
`endif

    logic [ADDR_W-1:0] req_va;
    logic [DATA_W-1:0] req_wdata;
    logic              req_wr;
    logic [ADDR_W-1:0] pa;
    logic [ADDR_W-1:0] walk_addr;

    logic              read_valid_r;
    logic              write_done_r;
    logic              fault_r;
    logic [DATA_W-1:0] read_data_r;
    logic [ADDR_W-1:0] fault_addr_r;

    logic              req_take;
    logic [VPN_W-1:0]  req_vpn;
    logic              hit;
    logic [IDX_W-1:0]  hit_idx;
    logic [VPN_W-1:0]  hit_ppn;
    logic [VPN_W-1:0]  pte_ppn;
    logic              pte_valid;
    logic              hit_wp_fault;
    logic              walk_wp_fault;
    logic              fill_en;

    assign req_take  = io.cpu_read | io.cpu_write;
    assign req_vpn   = req_va[ADDR_W-1:PAGE_BITS];
    assign pte_ppn   = io.mem_read_data[DATA_W-1:PAGE_BITS];
    assign pte_valid = io.mem_read_data[0];
    assign hit_ppn   = tlb_ppn[hit_idx];
    assign fill_en   = (state == S_WALK) && io.mem_ready && pte_valid;

    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = 0; i < TLB_ENTRIES; i++) begin
            if (tlb_vld[i] && (tlb_vpn[i] == req_vpn)) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
            end
        end
    end

`ifdef MMU_WRITE_PROTECT_EN
    assign hit_wp_fault  = req_wr && !tlb_wr[hit_idx];
    assign walk_wp_fault = req_wr && !io.mem_read_data[1];
`else
    assign hit_wp_fault  = 1'b0;
    assign walk_wp_fault = 1'b0;
`endif

    // Request, translation and TLB payload registers: qualified by state, never reset.
    always_ff @(posedge clk) begin
        if (state == S_IDLE && req_take) begin
            req_va    <= io.cpu_address;
            req_wdata <= io.cpu_write_data;
            req_wr    <= io.cpu_write;
        end
        if (state == S_XLATE) begin
            walk_addr <= pt_base + ADDR_W'({req_vpn, 2'b00});
            pa        <= translate_en ? {hit_ppn, req_va[PAGE_BITS-1:0]} : req_va;
        end
        if (state == S_WALK && io.mem_ready) begin
            pa <= {pte_ppn, req_va[PAGE_BITS-1:0]};
        end
        if (fill_en) begin
            tlb_vpn[rr_ptr] <= req_vpn;
            tlb_ppn[rr_ptr] <= pte_ppn;
`ifdef MMU_WRITE_PROTECT_EN
            tlb_wr[rr_ptr]  <= io.mem_read_data[1];
`endif
        end
    end

    // Control state; a flush overrides a same-edge fill of the valid bit and pointer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            rr_ptr       <= '0;
            tlb_vld      <= '0;
            read_valid_r <= 1'b0;
            write_done_r <= 1'b0;
            fault_r      <= 1'b0;
            read_data_r  <= '0;
            fault_addr_r <= '0;
        end else begin
            read_valid_r <= 1'b0;
            write_done_r <= 1'b0;
            fault_r      <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req_take) state <= S_XLATE;
                end
                S_XLATE: begin
                    if (!translate_en) begin
                        state <= S_ACCESS;
                    end else if (hit) begin
                        if (hit_wp_fault) begin
                            fault_r      <= 1'b1;
                            fault_addr_r <= req_va;
                            state        <= S_IDLE;
                        end else begin
                            state <= S_ACCESS;
                        end
                    end else begin
                        state <= S_WALK;
                    end
                end
                S_WALK: begin
                    if (io.mem_ready) begin
                        if (pte_valid) begin
                            tlb_vld[rr_ptr] <= 1'b1;
                            rr_ptr          <= rr_ptr + IDX_W'(1);
                        end
                        if (!pte_valid || walk_wp_fault) begin
                            fault_r      <= 1'b1;
                            fault_addr_r <= req_va;
                            state        <= S_IDLE;
                        end else begin
                            state <= S_ACCESS;
                        end
                    end
                end
                S_ACCESS: begin
                    if (io.mem_ready) begin
                        if (req_wr) begin
                            write_done_r <= 1'b1;
                        end else begin
                            read_valid_r <= 1'b1;
                            read_data_r  <= io.mem_read_data;
                        end
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
            if (tlb_flush) begin
                tlb_vld <= '0;
                rr_ptr  <= '0;
            end
        end
    end

    assign io.cpu_ready      = (state == S_IDLE);
    assign io.cpu_read_valid = read_valid_r;
    assign io.cpu_read_data  = read_data_r;
    assign io.cpu_write_done = write_done_r;
    assign io.cpu_fault      = fault_r;
    assign io.cpu_fault_addr = fault_addr_r;

    assign io.mem_read       = (state == S_WALK) || (state == S_ACCESS && !req_wr);
    assign io.mem_write      = (state == S_ACCESS) && req_wr;
    assign io.mem_address    = (state == S_WALK)   ? walk_addr :
                               (state == S_ACCESS) ? pa : '0;
    assign io.mem_write_data = (state == S_ACCESS && req_wr) ? req_wdata : '0;
endmodule

// File: doc/mmu_tlb_walker.md
# mmu_tlb_walker

Parametrised memory management unit between the CPU load/store port and the memory bus. It translates virtual addresses through a fully associative TLB with round-robin replacement. On a miss it runs a hardware walk of a single-level page table in memory. Accesses are blocking (one outstanding request) and can fault on an invalid mapping or, optionally, on a write-protection violation.

## Interface
Parameters:
- ADDR_W, 32, virtual and physical address width; equals DATA_W
- DATA_W, 32, data and PTE width
- PAGE_BITS, 12, page offset width; VPN/PPN width = ADDR_W-PAGE_BITS
- TLB_ENTRIES, 8, TLB entries, power of two, ≥2

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high
- cpu_address  in  ADDR_W  virtual address
- cpu_read  in  1  read request
- cpu_write  in  1  write request
- cpu_write_data  in  DATA_W  store data
- cpu_ready  out  1  request accepted on an edge where ready & (read|write)
- cpu_read_valid  out  1  one-cycle pulse, cpu_read_data valid
- cpu_read_data  out  DATA_W  load data, held until next load completes
- cpu_write_done  out  1  one-cycle pulse, store completed
- cpu_fault  out  1  one-cycle pulse, request aborted
- cpu_fault_addr  out  ADDR_W  virtual address of last fault, held
- translate_en  in  1  0 = physical = virtual, TLB bypassed
- pt_base  in  ADDR_W  page table base, word aligned
- tlb_flush  in  1  invalidate all TLB entries
- mem_read  out  1  bus read, held until mem_ready
- mem_write  out  1  bus write, held until mem_ready
- mem_address  out  ADDR_W  bus address
- mem_write_data  out  DATA_W  bus store data
- mem_read_data  in  DATA_W  valid in mem_ready cycle
- mem_ready  in  1  bus acknowledge

## Operation
- PTE at pt_base + (VPN << 2); PTE[ADDR_W-1:PAGE_BITS] = PPN, bit0 = valid, bit1 = writable.
- FSM states:
  - IDLE: cpu_ready=1; accepted request registers address, data and op, then goes to XLATE. cpu_read and cpu_write both high counts as a write.
  - XLATE: if translate_en=0, go to ACCESS with PA=VA. On a TLB hit (valid entry with matching VPN), PA={PPN, offset} and go to ACCESS. On a miss, go to WALK.
  - WALK: mem_read=1, mem_address=PTE address. On mem_ready, capture the PTE. An invalid PTE faults. A valid PTE writes an entry at the round-robin pointer, increments the pointer modulo TLB_ENTRIES, and goes to ACCESS.
  - ACCESS: mem_read or mem_write to PA. On mem_ready, pulse cpu_read_valid (register mem_read_data) or cpu_write_done, then go to IDLE.
  - Fault: pulse cpu_fault, load cpu_fault_addr, return to IDLE. No data access is issued.
- tlb_flush clears all valid bits on the next edge in any state and resets the pointer to 0. If a flush coincides with a WALK fill, the flush wins: the entry is left invalid, but the current access still uses the walked PTE.
- mem_* are decoded from the state register and registered request only. There is no combinational path from cpu_*.
- translate_en and pt_base are sampled in XLATE/WALK. Software changes them only when the unit is idle.

## Timing
- Reset (asynchronous, immediate): state IDLE, all TLB entries invalid, pointer 0. Outputs: cpu_ready=1, mem_read=0, mem_write=0, pulses=0, cpu_read_data=0, cpu_fault_addr=0, mem_address=0, mem_write_data=0.
- Reset during WALK or ACCESS abandons the bus transaction immediately. No response is produced.
- Hit, zero-wait bus: accepted at edge E0, XLATE, ACCESS, pulse in the cycle after E2. cpu_ready returns to 1 in that same cycle.
- Miss, zero-wait bus: pulse in the cycle after E3. Each mem_ready wait adds one cycle per bus phase.
- Back-to-back: a new request can be accepted in the pulse cycle.

## Configuration
- MMU_WRITE_PROTECT_EN defined: a write whose PTE or TLB entry has writable=0 faults, in both the hit and the walk paths. The TLB stores the writable bit.
- Not defined: bit1 is ignored, no writable bit is stored, and writes never fault on permissions.

## Test plan
- Walk then hit: translate_en=1, pt_base=0x1000, PTE at 0x1004=0x0000_5003, read VA 0x0000_1234. Required: WALK reads 0x1004, then ACCESS reads 0x5234, cpu_read_valid with bus data. Repeat the read: no walk, pulse after 2 cycles.
- Invalid PTE: PTE at 0x1008 = 0, write VA 0x2010. Required: cpu_fault pulse, cpu_fault_addr=0x2010, mem_write never asserted.
- Replacement: TLB_ENTRIES=8, touch VPNs 0..8. Required: re-access of VPN0 walks again, VPN8 hits.
- Flush vs fill: assert tlb_flush in the WALK mem_ready cycle. Required: the access completes, and the same VPN walks on its next access.
- Write protect (macro on): PTE 0x0000_7001, write VA 0x3000. Required: fault. With the macro off: mem_write to 0x7000, cpu_write_done.
- Reset mid-ACCESS with mem_ready=0. Required: mem_read=0 immediately, no cpu_read_valid, and a subsequent access walks.
